// File: rtl/pipe_meat_chain.sv
// Parametrised in-order pipeline register chain with per-stage hold, flush of younger
// stages, valid/ready output handshake and a saturating input-stall counter.
module pipe_meat_chain #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FL_W   = $clog2(STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stage_hold,
  input  logic                      flush,
  input  logic [FL_W-1:0]           flush_upto,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [CNT_W-1:0]          stall_count
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]              cnt_q;

  logic [STAGES-1:0] adv, take, kill, load;
  logic              kill_all;
  logic              stall;

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      kill[i] = flush & (i < 32'(flush_upto));
    end
    kill_all = flush & (32'(flush_upto) >= STAGES);
  end

  // Readiness ripples from the oldest stage down to stage 0.
  always_comb begin
    adv = '0;
    take = '0;
    adv[STAGES-1]  = valid_q[STAGES-1] & ~stage_hold[STAGES-1] & out_ready & ~kill[STAGES-1];
    take[STAGES-1] = ~stage_hold[STAGES-1] & (~valid_q[STAGES-1] | adv[STAGES-1]);
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i]  = valid_q[i] & ~stage_hold[i] & take[i+1];
      take[i] = ~stage_hold[i] & (~valid_q[i] | adv[i]);
    end
  end

  assign in_ready = take[0] & ~flush & ~rst;

  always_comb begin
    load = '0;
    load[0] = in_valid & in_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1] & ~kill[i-1];
    end
  end

  // Kill beats load and hold; stale data stays in empty stages.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (load[i]) begin
        valid_d[i] = 1'b1;
      end else if (adv[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (load[0]) begin
      data_d[0] = in_data;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (load[i]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  assign stall = in_valid & ~in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_valid   = valid_q[STAGES-1] & ~kill_all;
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_meat_chain.sv
// Directed bench for pipe_meat_chain: streaming, hold, flush, saturation and async reset.
module tb_pipe_meat_chain;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;
  localparam int unsigned FL_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic [STAGES-1:0]        stage_hold;
  logic                     flush;
  logic [FL_W-1:0]          flush_upto;
  logic                     out_ready;

  logic                     in_ready, out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*WIDTH-1:0]  stage_data;
  logic [15:0]              stall_count;

  logic                     sat_in_ready, sat_out_valid;
  logic [WIDTH-1:0]         sat_out_data;
  logic [STAGES-1:0]        sat_stage_valid;
  logic [STAGES*WIDTH-1:0]  sat_stage_data;
  logic [2:0]               sat_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_meat_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stage_hold(stage_hold), .flush(flush), .flush_upto(flush_upto),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_valid(stage_valid), .stage_data(stage_data), .stall_count(stall_count)
  );

  pipe_meat_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(sat_in_ready),
    .stage_hold(stage_hold), .flush(flush), .flush_upto(flush_upto),
    .out_valid(sat_out_valid), .out_data(sat_out_data), .out_ready(out_ready),
    .stage_valid(sat_stage_valid), .stage_data(sat_stage_data),
    .stall_count(sat_stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stage_hold = '0;
    flush = 1'b0; flush_upto = '0; out_ready = 1'b1;
    #2;
    check("rst_sv", 64'(stage_valid), 64'h0);
    check("rst_ov", 64'(out_valid), 64'h0);
    check("rst_od", 64'(out_data), 64'h0);
    check("rst_rdy", 64'(in_ready), 64'h0);
    check("rst_cnt", 64'(stall_count), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();

    // Streaming: first output 4 cycles after the first accept cycle.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k + 1);
      #1;
      check("strm_rdy", 64'(in_ready), 64'h1);
      check("strm_ov", 64'(out_valid), 64'(k >= 4));
      if (k >= 4) check("strm_od", 64'(out_data), 64'(k - 3));
      step();
    end

    // Hold stage 2 for three cycles with a full pipe.
    for (int k = 0; k < 3; k++) begin
      stage_hold = 4'b0100;
      in_data    = 16'd11;
      #1;
      check("hold_rdy", 64'(in_ready), 64'h0);
      check("hold_cnt", 64'(stall_count), 64'(k));
      if (k == 0) begin
        check("hold_ov0", 64'(out_valid), 64'h1);
        check("hold_od0", 64'(out_data), 64'd7);
      end else begin
        check("hold_ov", 64'(out_valid), 64'h0);
        check("hold_sv", 64'(stage_valid), 64'b0111);
      end
      step();
    end
    stage_hold = '0;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'(11 + k);
      #1;
      check("rsm_rdy", 64'(in_ready), 64'h1);
      check("rsm_ov", 64'(out_valid), 64'(k >= 1));
      if (k == 0) check("rsm_cnt", 64'(stall_count), 64'd3);
      if (k >= 1) check("rsm_od", 64'(out_data), 64'(7 + k));
      step();
    end

    // Pipe holds 11,12,13,14 (stage 3..0); flush stages 0..1.
    in_data = 16'd15; flush = 1'b1; flush_upto = 3'd2;
    #1;
    check("fl2_rdy", 64'(in_ready), 64'h0);
    check("fl2_ov", 64'(out_valid), 64'h1);
    check("fl2_od", 64'(out_data), 64'd11);
    step();
    flush = 1'b0; flush_upto = '0; in_valid = 1'b0;
    #1;
    check("fl2_sv", 64'(stage_valid), 64'b1000);
    check("fl2_od2", 64'(out_data), 64'd12);
    check("fl2_cnt", 64'(stall_count), 64'd3);
    step();
    check("fl2_sv2", 64'(stage_valid), 64'h0);
    check("fl2_ov2", 64'(out_valid), 64'h0);

    // Fill, then flush everything while the output is being offered.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h21 + k);
      step();
    end
    in_valid = 1'b0;
    #1;
    check("fl4_ov_pre", 64'(out_valid), 64'h1);
    check("fl4_od_pre", 64'(out_data), 64'h21);
    check("fl4_sv_pre", 64'(stage_valid), 64'b1111);
    flush = 1'b1; flush_upto = 3'd4;
    #1;
    check("fl4_ov", 64'(out_valid), 64'h0);
    check("fl4_rdy", 64'(in_ready), 64'h0);
    step();
    flush = 1'b0; flush_upto = '0;
    #1;
    check("fl4_sv", 64'(stage_valid), 64'h0);

    // Single item in stage 0 blocked by a hold on stage 1.
    in_valid = 1'b1; in_data = 16'h00AA;
    step();
    in_valid = 1'b0; stage_hold = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("h1_rdy", 64'(in_ready), 64'h0);
      check("h1_sv", 64'(stage_valid), 64'b0001);
      check("h1_d0", 64'(stage_data[15:0]), 64'h00AA);
      step();
    end
    stage_hold = '0;
    step();
    step();
    check("h1_sv2", 64'(stage_valid), 64'b0100);
    check("h1_ov2", 64'(out_valid), 64'h0);
    step();
    check("h1_ov3", 64'(out_valid), 64'h1);
    check("h1_od3", 64'(out_data), 64'h00AA);

    // Backpressure: fill behind a stuck output, then stall 10 cycles.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 16'(16'h31 + k);
      step();
    end
    in_data = 16'h0034;
    #1;
    check("bp_rdy", 64'(in_ready), 64'h0);
    check("bp_sv", 64'(stage_valid), 64'b1111);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) check("sat_cnt6", 64'(sat_stall_count), 64'd6);
      if (k == 4) check("sat_cnt7", 64'(sat_stall_count), 64'd7);
      step();
    end
    check("bp_cnt", 64'(stall_count), 64'd13);
    check("sat_cnt", 64'(sat_stall_count), 64'd7);
    check("bp_od", 64'(out_data), 64'h00AA);
    check("bp_d0", 64'(stage_data[15:0]), 64'h0033);

    // Asynchronous reset mid-stream.
    #1 rst = 1'b1;
    #1;
    check("arst_sv", 64'(stage_valid), 64'h0);
    check("arst_ov", 64'(out_valid), 64'h0);
    check("arst_od", 64'(out_data), 64'h0);
    check("arst_rdy", 64'(in_ready), 64'h0);
    check("arst_cnt", 64'(stall_count), 64'h0);
    check("arst_scnt", 64'(sat_stall_count), 64'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b0;
    step();
    check("post_sv", 64'(stage_valid), 64'h0);
    check("post_cnt", 64'(stall_count), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_meat_chain.md
Name: pipe_meat_chain

Overview:
- Parametrised successor to the fixed per-stage pipeline latches between IF, ID, IE, MEM and WB.
- One block holds STAGES in-order stage registers of WIDTH-bit payload, each with a valid bit.
- Adds per-stage hold with backpressure, bubble insertion on drain, flush of the younger stages from a given stage index, a valid/ready output handshake, and a saturating stall counter.
- Stage 0 is the youngest stage (IF/ID side). Stage STAGES-1 is the oldest and drives the output.

Parameters:
- WIDTH, 16, payload bits per stage (ipacket plus operand words).
- STAGES, 4, number of stage registers; must be 2 or more.
- CNT_W, 16, width of the stall counter.
- FL_W, $clog2(STAGES+1), width of flush_upto.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer offers in_data.
- in_data  in  WIDTH  payload entering stage 0.
- in_ready  out  1  stage 0 accepts this cycle (combinational).
- stage_hold  in  STAGES  bit i: stage i is busy, e.g. memory response pending; its contents freeze.
- flush  in  1  kill the younger stages (branch taken or redirect).
- flush_upto  in  FL_W  flush stages 0..flush_upto-1.
- out_valid  out  1  stage STAGES-1 holds a live item.
- out_data  out  WIDTH  payload of stage STAGES-1.
- out_ready  in  1  consumer takes the output.
- stage_valid  out  STAGES  valid bit of each stage.
- stage_data  out  STAGES*WIDTH  payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- stall_count  out  CNT_W  saturating count of input stall cycles.

Behaviour:
- Reset (async, rst=1):
  - All valid bits, data registers and stall_count go to 0 immediately.
  - Outputs read out_valid=0, out_data=0, stage_valid=0.
  - in_ready is 0 while rst is high.
  - Reset mid-stream discards all in-flight items; no partial transfer completes on the edge where rst deasserts.
- Advance logic (combinational):
  - Last stage: adv[N-1] = valid[N-1] & ~hold[N-1] & out_ready & ~kill[N-1].
  - Other stages: adv[i] = valid[i] & ~hold[i] & take[i+1].
  - take[i] = ~hold[i] & (~valid[i] | adv[i]).
  - kill[i] = flush & (i < flush_upto).
- Input handshake:
  - in_ready = take[0] & ~flush.
  - A transfer occurs when in_valid & in_ready; stage 0 loads in_data with valid=1.
- Stage i>0 update:
  - Loads data[i-1] with valid=1 when adv[i-1] & ~kill[i-1].
  - Otherwise, if adv[i], valid becomes 0 (bubble).
  - Otherwise it holds.
  - A data register changes only on a load; invalid stages keep stale data.
- Hold:
  - hold[i] freezes stage i whether it is valid or empty.
  - All older stages drain and bubble. All younger stages back up through take.
- Flush:
  - On the next edge, valid[j]=0 for every j < flush_upto, regardless of hold.
  - Stage flush_upto may advance but cannot load from the killed stage below it, so it bubbles.
  - Stages at or above flush_upto behave normally.
  - flush_upto=0: no stage is killed, but in_ready is still 0 that cycle.
  - flush_upto >= STAGES: every stage is killed, and out_valid is forced to 0 that cycle.
- Output:
  - out_valid = valid[N-1] & ~(flush & flush_upto >= STAGES).
  - out_data = data[N-1].
- Latency:
  - An item accepted at edge t with no holds is visible at stage STAGES-1 after edge t+STAGES-1.
  - Full throughput is one item per cycle.
- stall_count:
  - Increments on each cycle where in_valid & ~in_ready & ~flush & ~rst.
  - Saturates at 2^CNT_W-1; it never wraps.
- Simultaneous hold[i] and flush covering stage i: flush wins and the stage becomes invalid.

Test Plan (STAGES=4, WIDTH=16 unless stated):
- Stream: in_valid=1 with data 0x0001, 0x0002, ... each cycle, out_ready=1, no hold -> in_ready stays 1; out_valid first rises 3 edges after accepting 0x0001; outputs appear in order, one per cycle, with no gaps.
- Full pipe, then stage_hold=4'b0100 for 3 cycles -> stages 0-2 freeze; stage 3 emits its item then bubbles (out_valid=0 for 2 cycles); in_ready=0 for 3 cycles; stall_count goes from 0 to 3; stream resumes intact, with no item lost or duplicated.
- Pipe holding A (stage 3), B, C, D (stage 0); pulse flush with flush_upto=2 -> next cycle stage_valid=4'b1000 with B in stage 3; C and D are never output; in_ready=0 during the flush cycle.
- flush with flush_upto=4 while out_valid=1 and out_ready=1 -> out_valid reads 0 that cycle; all valid bits are 0 next cycle; out_ready has no effect.
- Only stage 0 valid (0x00AA), stage_hold=4'b0010 -> 0x00AA stays in stage 0 and in_ready=0; after the hold is released it reaches the output 3 cycles later.
- CNT_W=3: out_ready=0 with a full pipe and in_valid=1 for 10 cycles -> stall_count saturates at 7. Asserting rst mid-stream -> stage_valid=0 and stall_count=0 immediately, without waiting for a clock edge.
